// File: rtl/rs485_port_mux.sv
// ---------------------------------------------------------------------------
// rs485_port_mux
//
// Routes N_SRC serial TX sources onto N_CH half-duplex RS-485 transceivers.
// Each channel is OFF, TX (driving a selected source), RX (listening) or in
// TURN, a dead-time window that separates any two different modes so that a
// driver and a receiver are never enabled together on the same transceiver.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   cfg_we            one-cycle configuration write strobe
//   cfg_ch            target channel index
//   cfg_mode          00 OFF, 01 TX, 10 RX, 11 illegal
//   cfg_src           TX source index (checked only for TX writes)
//   cfg_ack, cfg_err  one-cycle accept / reject pulse, cycle after cfg_we
//   src_d             serial source bits
//   ch_r              transceiver receiver outputs (asynchronous)
//   ch_d              transceiver driver inputs
//   ch_de             driver enable, active-high
//   ch_nre            receiver enable, active-low
//   rx_q              synchronised receive data, idle-high outside RX
//   ch_busy           channel is in its turnaround window
//
// Config handshake: cfg_we is a single-cycle strobe with no backpressure.
// Every cycle with cfg_we=1 is answered in the next cycle by exactly one of
// cfg_ack (write applied) or cfg_err (write dropped, no state change).
//
// The per-channel FSM state is fully observable on the registered outputs:
// OFF (de=0,nre=1,busy=0), TX (de=1), RX (nre=0), TURN (busy=1).
// ---------------------------------------------------------------------------
module rs485_port_mux #(
   parameter int N_CH  = 22,
   parameter int N_SRC = 4,
   parameter int GUARD = 8,
   localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
   localparam int SRC_W = $clog2(N_SRC),
   localparam int CNT_W = $clog2(GUARD + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [1:0]       cfg_mode,
   input  logic [SRC_W-1:0] cfg_src,
   output logic             cfg_ack,
   output logic             cfg_err,
   input  logic [N_SRC-1:0] src_d,
   input  logic [N_CH-1:0]  ch_r,
   output logic [N_CH-1:0]  ch_d,
   output logic [N_CH-1:0]  ch_de,
   output logic [N_CH-1:0]  ch_nre,
   output logic [N_CH-1:0]  rx_q,
   output logic [N_CH-1:0]  ch_busy
);

   // Encoding of OFF/TX/RX matches cfg_mode so a same-mode write can be
   // detected with a direct compare.
   typedef enum logic [1:0] {
      ST_OFF  = 2'b00,
      ST_TX   = 2'b01,
      ST_RX   = 2'b10,
      ST_TURN = 2'b11
   } state_t;

   state_t           state     [N_CH];
   state_t           nxt_state [N_CH];
   state_t           tgt       [N_CH];
   state_t           nxt_tgt   [N_CH];
   logic [SRC_W-1:0] src_sel   [N_CH];
   logic [SRC_W-1:0] nxt_src   [N_CH];
   logic [CNT_W-1:0] cnt       [N_CH];
   logic [CNT_W-1:0] nxt_cnt   [N_CH];

   // First synchroniser stage for ch_r; rx_q itself is the second stage.
   logic [N_CH-1:0]  sync1;

   logic             ch_ok;
   logic             src_ok;
   logic             tgt_busy;
   logic             wr_reject;
   logic             wr_accept;
   logic [CH_W-1:0]  ch_idx;

   // Write validation. ch_idx is clamped so the TURN lookup never indexes
   // past the channel array when cfg_ch is out of range.
   always_comb begin
      ch_ok     = (int'(cfg_ch) < N_CH);
      ch_idx    = ch_ok ? cfg_ch : '0;
      src_ok    = (int'(cfg_src) < N_SRC);
      tgt_busy  = (state[ch_idx] == ST_TURN);
      wr_reject = !ch_ok
                || (cfg_mode == 2'b11)
                || ((cfg_mode == 2'b01) && !src_ok)
                || tgt_busy;
      wr_accept = cfg_we && !wr_reject;
   end

   // Next-state for every channel. A channel in TURN ignores writes (they
   // are rejected above), counts down to zero and then enters its target.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         nxt_state[i] = state[i];
         nxt_tgt[i]   = tgt[i];
         nxt_src[i]   = src_sel[i];
         nxt_cnt[i]   = cnt[i];
         if (state[i] == ST_TURN) begin
            if (cnt[i] == '0) begin
               nxt_state[i] = tgt[i];
            end else begin
               nxt_cnt[i] = cnt[i] - 1'b1;
            end
         end else if (wr_accept && (int'(cfg_ch) == i)) begin
            if (cfg_mode == state[i]) begin
               // Re-selecting the source while already driving needs no
               // dead time: the driver stays enabled throughout.
               if (state[i] == ST_TX) begin
                  nxt_src[i] = cfg_src;
               end
            end else begin
               nxt_state[i] = ST_TURN;
               nxt_cnt[i]   = CNT_W'(GUARD);
               nxt_tgt[i]   = state_t'(cfg_mode);
               nxt_src[i]   = cfg_src;
            end
         end
      end
   end

   // State and registered output decode. Outputs are decoded from the
   // next state so they change in the same cycle as the state register,
   // and ch_d carries src_d with exactly one cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_ack <= 1'b0;
         cfg_err <= 1'b0;
         sync1   <= '1;
         ch_d    <= '0;
         ch_de   <= '0;
         ch_nre  <= '1;
         ch_busy <= '0;
         rx_q    <= '1;
         for (int i = 0; i < N_CH; i++) begin
            state[i]   <= ST_OFF;
            tgt[i]     <= ST_OFF;
            src_sel[i] <= '0;
            cnt[i]     <= '0;
         end
      end else begin
         cfg_ack <= wr_accept;
         cfg_err <= cfg_we && wr_reject;
         sync1   <= ch_r;
         for (int i = 0; i < N_CH; i++) begin
            state[i]   <= nxt_state[i];
            tgt[i]     <= nxt_tgt[i];
            src_sel[i] <= nxt_src[i];
            cnt[i]     <= nxt_cnt[i];
            ch_de[i]   <= (nxt_state[i] == ST_TX);
            ch_nre[i]  <= (nxt_state[i] != ST_RX);
            ch_busy[i] <= (nxt_state[i] == ST_TURN);
            ch_d[i]    <= (nxt_state[i] == ST_TX) ? src_d[nxt_src[i]] : 1'b0;
            rx_q[i]    <= (nxt_state[i] == ST_RX) ? sync1[i] : 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rs485_port_mux.sv
// ---------------------------------------------------------------------------
// tb_rs485_port_mux
//
// Directed scenarios followed by randomized configuration traffic. The
// reference model tracks, per channel, the mode it is heading for, the
// first cycle in which that mode is live and the selected source; every
// output bit is derived from that plus a short history of src_d / ch_r.
// cfg responses go through an expected queue checked by a monitor.
// ---------------------------------------------------------------------------
module tb_rs485_port_mux;

   localparam int N_CH  = 22;
   localparam int N_SRC = 4;
   localparam int GUARD = 8;
   localparam int CH_W  = 5;
   localparam int SRC_W = 2;

   // Mode numbering used by the model: 0 OFF, 1 TX, 2 RX, 3 turnaround.
   localparam int M_OFF  = 0;
   localparam int M_TX   = 1;
   localparam int M_RX   = 2;
   localparam int M_TURN = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic             cfg_we   = 1'b0;
   logic [CH_W-1:0]  cfg_ch   = '0;
   logic [1:0]       cfg_mode = '0;
   logic [SRC_W-1:0] cfg_src  = '0;
   logic             cfg_ack;
   logic             cfg_err;
   logic [N_SRC-1:0] src_d    = '0;
   logic [N_CH-1:0]  ch_r     = '0;
   logic [N_CH-1:0]  ch_d;
   logic [N_CH-1:0]  ch_de;
   logic [N_CH-1:0]  ch_nre;
   logic [N_CH-1:0]  rx_q;
   logic [N_CH-1:0]  ch_busy;

   rs485_port_mux #(
      .N_CH  (N_CH),
      .N_SRC (N_SRC),
      .GUARD (GUARD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_mode (cfg_mode),
      .cfg_src  (cfg_src),
      .cfg_ack  (cfg_ack),
      .cfg_err  (cfg_err),
      .src_d    (src_d),
      .ch_r     (ch_r),
      .ch_d     (ch_d),
      .ch_de    (ch_de),
      .ch_nre   (ch_nre),
      .rx_q     (rx_q),
      .ch_busy  (ch_busy)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int n_resp   = 0;
   int cyc      = 0;

   // Expected cfg responses: {cycle[30:0], accepted}
   logic [31:0] exp_q[$];

   // ---------------- reference model ----------------
   int m_tgt [N_CH];   // mode the channel is in or heading for
   int m_end [N_CH];   // first cycle in which m_tgt is live
   int m_src [N_CH];
   logic [N_SRC-1:0] s_prev;   // src_d during the previous cycle
   logic [N_CH-1:0]  r_prev1;  // ch_r one cycle back
   logic [N_CH-1:0]  r_prev2;  // ch_r two cycles back

   function automatic int eff_mode(input int i);
      return (cyc >= m_end[i]) ? m_tgt[i] : M_TURN;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_tgt[i] = M_OFF;
         m_end[i] = 0;
         m_src[i] = 0;
      end
   endtask

   // Called at the clock edge that samples a write presented in cycle cyc-1.
   task automatic model_write(input int ch, input int mode, input int src);
      bit ok;
      ok = 1'b1;
      if (ch >= N_CH) ok = 1'b0;
      else if (mode == 3) ok = 1'b0;
      else if (mode == M_TX && src >= N_SRC) ok = 1'b0;
      else if ((cyc - 1) < m_end[ch]) ok = 1'b0;
      exp_q.push_back({cyc[30:0], ok});
      if (ok) begin
         if (mode == m_tgt[ch]) begin
            if (mode == M_TX) m_src[ch] = src;
         end else begin
            m_tgt[ch] = mode;
            m_end[ch] = cyc + GUARD + 1;
            m_src[ch] = src;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- driver ----------------
   // Presents one cycle of stimulus (called just after a rising edge),
   // waits for the next edge and advances the model.
   task automatic tick(input bit we, input int ch, input int mode, input int src);
      cfg_we   = we;
      cfg_ch   = ch[CH_W-1:0];
      cfg_mode = mode[1:0];
      cfg_src  = src[SRC_W-1:0];
      src_d    = N_SRC'($urandom);
      ch_r     = N_CH'($urandom);
      if (we && !rst) n_writes++;
      @(posedge clk);
      cyc++;
      if (we && !rst) model_write(ch, mode, src);
      r_prev2 = r_prev1;
      r_prev1 = ch_r;
      s_prev  = src_d;
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick(1'b0, 0, 0, 0);
   endtask

   // Asynchronous reset pulse landing in the middle of a cycle.
   task automatic reset_pulse();
      logic [N_CH-1:0] ones;
      ones = '1;
      idle(1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("rst_async_de",      64'(ch_de),   64'(0));
      check("rst_async_nre",     64'(ch_nre),  64'(ones));
      check("rst_async_d",       64'(ch_d),    64'(0));
      check("rst_async_busy",    64'(ch_busy), 64'(0));
      check("rst_async_rx_q",    64'(rx_q),    64'(ones));
      check("rst_async_ack_err", 64'({cfg_ack, cfg_err}), 64'(0));
      idle(2);
      rst = 1'b0;
   endtask

   // ---------------- monitor ----------------
   task automatic monitor_cycle();
      logic [N_CH-1:0] e_de, e_nre, e_busy, e_d, e_rx;
      logic [31:0]     e;
      int m;
      for (int i = 0; i < N_CH; i++) begin
         m         = eff_mode(i);
         e_de[i]   = (m == M_TX);
         e_nre[i]  = (m != M_RX);
         e_busy[i] = (m == M_TURN);
         e_d[i]    = (m == M_TX) ? s_prev[m_src[i]] : 1'b0;
         e_rx[i]   = (m == M_RX) ? r_prev2[i] : 1'b1;
      end
      check("ch_de",   64'(ch_de),   64'(e_de));
      check("ch_nre",  64'(ch_nre),  64'(e_nre));
      check("ch_busy", 64'(ch_busy), 64'(e_busy));
      check("ch_d",    64'(ch_d),    64'(e_d));
      check("rx_q",    64'(rx_q),    64'(e_rx));
      check("de_with_rx_enabled", 64'(|(ch_de & ~ch_nre)), 64'(0));

      if (cfg_ack === 1'b1 || cfg_err === 1'b1) begin
         n_resp++;
         check("ack_err_exclusive", 64'(cfg_ack & cfg_err), 64'(0));
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL cfg_resp: got ack=%0b err=%0b at cycle %0d, expected no response",
                     cfg_ack, cfg_err, cyc);
         end else begin
            e = exp_q.pop_front();
            check("cfg_resp", 64'({cyc[30:0], cfg_ack}), 64'(e));
         end
      end else if (exp_q.size() > 0 && exp_q[0][31:1] <= cyc[30:0]) begin
         e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL cfg_resp: got no response at cycle %0d, expected ack=%0b",
                  cyc, e[0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         monitor_cycle();
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout at cycle %0d, expected test end", cyc);
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      int ch, mode, src;
      bit we;
      model_reset();
      s_prev  = '0;
      r_prev1 = '0;
      r_prev2 = '0;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      idle(3);

      // TX bring-up on channel 0, source 2
      tick(1'b1, 0, M_TX, 2);
      idle(14);
      // same-mode source change, no turnaround
      tick(1'b1, 0, M_TX, 1);
      idle(4);
      // channel 3: TX then RX
      tick(1'b1, 3, M_TX, 0);
      idle(11);
      tick(1'b1, 3, M_RX, 0);
      idle(16);
      // rejects: bad channel, illegal mode, write to a busy channel
      tick(1'b1, N_CH, M_TX, 0);
      tick(1'b1, 5, 3, 0);
      tick(1'b1, 3, M_TX, 0);
      tick(1'b1, 3, M_OFF, 0);
      idle(12);
      // back-to-back writes to different channels
      tick(1'b1, 1, M_RX, 0);
      tick(1'b1, 2, M_TX, 3);
      tick(1'b1, 4, M_RX, 0);
      tick(1'b1, N_CH - 1, M_TX, 1);
      idle(12);
      // reset in the middle of a turnaround
      tick(1'b1, 6, M_TX, 1);
      idle(4);
      reset_pulse();
      idle(GUARD + 6);

      // randomized traffic
      for (int n = 0; n < 10000; n++) begin
         we   = ($urandom_range(0, 9) != 0);
         ch   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(N_CH, 31))
                                            : int'($urandom_range(0, N_CH - 1));
         mode = int'($urandom_range(0, 3));
         src  = int'($urandom_range(0, N_SRC - 1));
         tick(we, ch, mode, src);
         if (n % 2500 == 2499) reset_pulse();
      end
      idle(GUARD + 4);

      check("resp_count", 64'(n_resp), 64'(n_writes));
      check("exp_q_empty", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rs485_port_mux.md
RS485_PORT_MUX -- requirements
Module: rs485_port_mux

Interface
REQ-001 Parameter N_CH, default 22, number of RS-485 transceiver channels (1..32).
REQ-002 Parameter N_SRC, default 4, number of serial TX sources (2..8); CH_W = clog2(N_CH), SRC_W = clog2(N_SRC).
REQ-003 Parameter GUARD, default 8, driver-turnaround dead time in clk cycles (1..255).
REQ-004 clk  in  1  single system clock; all state on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cfg_we  in  1  configuration write strobe, one cycle.
REQ-007 cfg_ch  in  CH_W  target channel index.
REQ-008 cfg_mode  in  2  00 OFF, 01 TX, 10 RX, 11 illegal.
REQ-009 cfg_src  in  SRC_W  TX source index.
REQ-010 cfg_ack  out  1  one-cycle pulse: write accepted.
REQ-011 cfg_err  out  1  one-cycle pulse: write rejected.
REQ-012 src_d  in  N_SRC  serial source bits (com/dat lines).
REQ-013 ch_r  in  N_CH  transceiver receiver outputs (asynchronous).
REQ-014 ch_d  out  N_CH  transceiver driver inputs.
REQ-015 ch_de  out  N_CH  driver enable, active-high.
REQ-016 ch_nre  out  N_CH  receiver enable, active-low.
REQ-017 rx_q  out  N_CH  synchronised receive data.
REQ-018 ch_busy  out  N_CH  channel in turnaround.

Function
REQ-019 Each channel SHALL run an independent FSM with states OFF, TX, RX, TURN, plus registers mode_tgt, src_sel, and a guard counter of clog2(GUARD+1) bits.
REQ-020 Output decode SHALL be registered: OFF/TURN -> de=0, nre=1, d=0; TX -> de=1, nre=1, d=src_d[src_sel]; RX -> de=0, nre=0, d=0.
REQ-021 ch_de[i]=1 together with ch_nre[i]=0 SHALL never occur in any cycle.
REQ-022 TX data latency SHALL be exactly 1 cycle from src_d to ch_d.
REQ-023 A write SHALL be rejected (cfg_err=1 next cycle, no state change) if cfg_ch >= N_CH, cfg_mode = 11, cfg_src >= N_SRC with mode TX, or the target channel is in TURN.
REQ-024 Otherwise the write SHALL be accepted with cfg_ack=1 the cycle after cfg_we; cfg_ack and cfg_err are mutually exclusive.
REQ-025 Accepted write with mode equal to current state: TX updates src_sel at once (no guard); OFF/RX: no change.
REQ-026 Accepted write with a different mode: next cycle the state SHALL be TURN, counter = GUARD, mode_tgt = cfg_mode, src_sel = cfg_src.
REQ-027 TURN SHALL decrement the counter each cycle and enter mode_tgt in the cycle after it reaches 0, giving exactly GUARD+1 cycles with de=0, nre=1.
REQ-028 ch_busy[i] SHALL be 1 exactly while channel i is in TURN.
REQ-029 rx_q[i] SHALL be ch_r[i] through a 2-flop synchroniser when in RX, else forced 1 (idle); latency 2 cycles.
REQ-030 Only one write per cycle is processed; back-to-back writes to different channels in consecutive cycles SHALL all be processed.

Reset
REQ-031 On rst all channels SHALL go to OFF asynchronously: ch_d=0, ch_de=0, ch_nre=all 1, ch_busy=0, rx_q=all 1, cfg_ack=0, cfg_err=0, src_sel=0, counters=0.
REQ-032 rst asserted during TURN SHALL abort the turnaround; after release the channel remains OFF with no pending target.
REQ-033 Outputs SHALL leave reset values only after an accepted write plus turnaround.

Verification
REQ-034 Reset then write ch 0 TX src 2 -> ack at +1; busy for 9 cycles; de=1,nre=1 at +10; ch_d follows src_d[2] with 1-cycle lag.
REQ-035 Ch 0 in TX, write ch 0 TX src 1 -> ack, no TURN, ch_d switches to src_d[1] within 2 cycles.
REQ-036 Ch 3 TX -> write RX -> 9 cycles de=0,nre=1, then nre=0; ch_r toggled -> rx_q follows 2 cycles later.
REQ-037 Write ch 22 (N_CH=22), mode 11, or to a busy channel -> cfg_err pulse, all outputs unchanged.
REQ-038 rst pulse mid-TURN -> immediate OFF outputs; no mode entered after release.
REQ-039 Random 10k writes across all channels -> assertion de & ~nre never true; ack+err count equals write count.
